// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus timing definitions.
// Also used by the i4002/i4004 models.
package mcs4_pkg;

    typedef enum logic [2:0] {
        A1, A2, A3, M1, M2, X1, X2, X3
    } phase_t;

    localparam int TICKS_PER_PHASE = 4;
    localparam int PHI1_TICK       = 0;
    localparam int PHI2_TICK       = 2;
    localparam int SAMPLE_TICK     = 2;

    localparam logic [1:0] LAST_TICK =
        2'(TICKS_PER_PHASE - 1);

    function automatic logic is_tick(
        input logic [1:0] t,
        input int         n
    );
        return t == 2'(n);
    endfunction

endpackage

// File: rtl/mcs4_phase_gen.sv
// Tick/phase sequencer with PHI1, PHI2 and SYNC decode.
// Runs from X3 tick 0 one clock after reset release.
module mcs4_phase_gen
    import mcs4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] phase,
    output logic [1:0] tick,
    output logic       last_tick,
    output logic       phi1,
    output logic       phi2,
    output logic       sync
);

    phase_t     phase_q;
    phase_t     phase_d;
    logic [1:0] tick_q;
    logic [1:0] tick_d;
    logic       run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= X3;
            tick_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tick_q  <= tick_d;
            run_q   <= 1'b1;
        end
    end

    // Counters hold for the first clock so X3 tick 0 is visible.
    always_comb begin
        phase_d = phase_q;
        tick_d  = tick_q;
        if (run_q) begin
            tick_d = tick_q + 2'd1;
            if (tick_q == LAST_TICK) begin
                phase_d = phase_t'(3'(phase_q) + 3'd1);
            end
        end
    end

    assign phase     = phase_q;
    assign tick      = tick_q;
    assign last_tick = run_q && (tick_q == LAST_TICK);
    assign phi1      = run_q && is_tick(tick_q, PHI1_TICK);
    assign phi2      = run_q && is_tick(tick_q, PHI2_TICK);
    assign sync      = run_q && (phase_q == X3);

endmodule

// File: rtl/mcs4_rom_fetch.sv
// MCS-4 bus initiator fetching 8-bit instructions
// from i4001-style ROMs.
module mcs4_rom_fetch
    import mcs4_pkg::*;
(
    input  logic        clk_i,
    input  logic        RESET_i,
    input  logic        req_valid_i,
    input  logic [11:0] req_addr_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        PHI1_o,
    output logic        PHI2_o,
    output logic        SYNC_o,
    output logic        CM_o,
    output logic [3:0]  D_o,
    output logic        D_oe_o,
    input  logic [3:0]  D_i
);

    logic [2:0]  phase_w;
    phase_t      phase;
    logic [1:0]  tick;
    logic        last_tick;
    logic        active_q;
    logic [11:0] addr_q;
    logic [3:0]  opr_q;
    logic [3:0]  opa_q;
    logic        sample;

    mcs4_phase_gen u_phase_gen (
        .clk       (clk_i),
        .rst       (RESET_i),
        .phase     (phase_w),
        .tick      (tick),
        .last_tick (last_tick),
        .phi1      (PHI1_o),
        .phi2      (PHI2_o),
        .sync      (SYNC_o)
    );

    assign phase       = phase_t'(phase_w);
    assign req_ready_o = last_tick && (phase == X3);
    assign sample      = active_q && is_tick(tick, SAMPLE_TICK);

    // active spans one full instruction cycle, A1 through X3.
    always_ff @(posedge clk_i or posedge RESET_i) begin
        if (RESET_i) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            opr_q    <= '0;
            opa_q    <= '0;
        end else begin
            if (req_ready_o) begin
                active_q <= req_valid_i;
            end
            if (req_ready_o && req_valid_i) begin
                addr_q <= req_addr_i;
            end
            if (sample && (phase == M1)) begin
                opr_q <= D_i;
            end
            if (sample && (phase == M2)) begin
                opa_q <= D_i;
            end
        end
    end

    always_comb begin
        D_oe_o = 1'b0;
        D_o    = '0;
        CM_o   = 1'b0;
        if (active_q) begin
            unique case (phase)
                A1: begin
                    D_oe_o = 1'b1;
                    D_o    = addr_q[3:0];
                end
                A2: begin
                    D_oe_o = 1'b1;
                    D_o    = addr_q[7:4];
                end
                A3: begin
                    D_oe_o = 1'b1;
                    D_o    = addr_q[11:8];
                    CM_o   = 1'b1;
                end
                default: begin
                    D_oe_o = 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o =
        active_q && (phase == M2) && last_tick;
    assign rsp_data_o  = {opr_q, opa_q};

endmodule

// File: tb/tb_mcs4_rom_fetch.sv
// Directed bench for mcs4_rom_fetch with a
// response scoreboard and a timed ROM model.
module tb_mcs4_rom_fetch;

    logic        clk_i = 1'b0;
    logic        RESET_i;
    logic        req_valid_i;
    logic [11:0] req_addr_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        PHI1_o;
    logic        PHI2_o;
    logic        SYNC_o;
    logic        CM_o;
    logic [3:0]  D_o;
    logic        D_oe_o;
    logic [3:0]  D_i;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          hs_prev = 0;
    logic [7:0]  sb[$];

    mcs4_rom_fetch dut (
        .clk_i       (clk_i),
        .RESET_i     (RESET_i),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .PHI1_o      (PHI1_o),
        .PHI2_o      (PHI2_o),
        .SYNC_o      (SYNC_o),
        .CM_o        (CM_o),
        .D_o         (D_o),
        .D_oe_o      (D_oe_o),
        .D_i         (D_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({req_ready_o, rsp_valid_o,
                    rsp_data_o, PHI1_o, PHI2_o,
                    SYNC_o, CM_o, D_o, D_oe_o});
    endfunction

    // Called at a negedge. k counts cycles after
    // the handshake cycle c; M1 tick 2 = c+15,
    // M2 tick 2 = c+19, response at c+20.
    task automatic fetch(
        input logic [11:0] a,
        input logic [3:0]  opr,
        input logic [3:0]  opa,
        input bit          glitch,
        input bit          hold,
        input bit          chk_gap,
        input int          abort_k
    );
        int         n;
        logic [3:0] nib;
        logic [7:0] exp;
        req_addr_i  = a;
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk("hs_wait", 32'(n < 40), 1);
        if (n >= 40) begin
            req_valid_i = 1'b0;
            return;
        end
        hs_prev = hs_cyc;
        hs_cyc  = cyc;
        if (chk_gap) chk("b2b_gap", hs_cyc - hs_prev, 32);
        sb.push_back({opr, opa});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (k == 1 && !hold) req_valid_i = 1'b0;
            if (glitch)
                D_i = (k == 15) ? opr :
                      (k == 19) ? opa : 4'hF;
            else
                D_i = (k >= 13 && k <= 16) ? opr :
                      (k >= 17) ? opa : 4'h0;
            nib = 4'(a >> (4 * ((k - 1) / 4)));
            chk("d_oe", D_oe_o, 32'(k <= 12));
            chk("d_o", D_o, (k <= 12) ? nib : 0);
            chk("cm", CM_o, 32'(k >= 9 && k <= 12));
            chk("rsp_valid", rsp_valid_o, 32'(k == 20));
            if (rsp_valid_o) begin
                chk("sb_nonempty", sb.size(), 1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("rsp_data", rsp_data_o, exp);
                end
            end
            if (k == abort_k) begin
                RESET_i = 1'b1;
                #1;
                chk("abort_outs", all_outs(), 0);
                sb.delete();
                D_i = 4'h0;
                return;
            end
        end
        D_i = 4'h0;
    endtask

    initial begin : main
        int first;
        int last_rise;
        int p1;
        int p2;
        int bad;
        int hs;
        int n;
        logic prev;
        RESET_i     = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        D_i         = 4'h0;
        repeat (3) @(negedge clk_i);
        chk("reset_outs", all_outs(), 0);
        RESET_i = 1'b0;

        first = 0;
        last_rise = 0;
        p1 = 0;
        p2 = 0;
        bad = 0;
        prev = 1'b0;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk_i);
            if (k <= 64) begin
                p1 += int'(PHI1_o);
                p2 += int'(PHI2_o);
            end
            if ((PHI1_o && PHI2_o) || D_oe_o || CM_o ||
                rsp_valid_o) bad++;
            if (SYNC_o && !prev) begin
                if (first == 0) first = k;
                else chk("sync_period", k - last_rise, 32);
                last_rise = k;
            end
            prev = SYNC_o;
        end
        chk("sync_first", 32'(first >= 1 && first <= 4), 1);
        chk("phi1_count", p1, 16);
        chk("phi2_count", p2, 16);
        chk("idle_bus", bad, 0);

        fetch(12'h3A5, 4'hD, 4'h2, 0, 0, 0, 0);

        fetch(12'h000, 4'h1, 4'h4, 0, 1, 0, 0);
        fetch(12'hFFF, 4'h8, 4'hE, 0, 0, 1, 0);

        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!SYNC_o && n < 40);
        chk("sync_found", SYNC_o, 1);
        repeat (25) @(negedge clk_i);
        req_addr_i  = 12'hABC;
        req_valid_i = 1'b1;
        hs = 0;
        for (int k = 0; k < 3; k++) begin
            if (req_ready_o) hs++;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        chk("pulse_no_hs", hs, 0);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_i);
            if (D_oe_o || CM_o || rsp_valid_o) bad++;
        end
        chk("pulse_idle", bad, 0);

        fetch(12'h0C7, 4'h6, 4'h9, 1, 0, 0, 0);

        fetch(12'h5E1, 4'hA, 4'hB, 0, 0, 0, 14);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            if (all_outs() != 0) bad++;
        end
        chk("reset_hold", bad, 0);
        RESET_i = 1'b0;
        fetch(12'h123, 4'h7, 4'hC, 0, 0, 0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcs4_rom_fetch.md
# mcs4_rom_fetch

MCS-4 bus initiator that fetches 8-bit instruction bytes from i4001-style ROMs. It generates the two-phase bus clocks and SYNC and runs the fixed 8-subcycle instruction cycle. It drives the 12-bit address as three nibbles, asserts CM, and samples OPR/OPA from the data bus. It sits between a host/test harness (valid/ready request, pulsed response) and the ROM bus pins.

## Interface
- No parameters. Subcycle length is fixed at 4 clk_i ticks; address width is fixed at 12.
- clk_i  in  1  main design clock
- RESET_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  fetch request valid
- req_addr_i  in  12  ROM address {page[3:0], offset[7:0]}
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
- rsp_valid_o  out  1  one-clk pulse, fetched byte valid
- rsp_data_o  out  8  {OPR[3:0], OPA[3:0]}
- PHI1_o  out  1  clock phase 1, active-high logic level
- PHI2_o  out  1  clock phase 2, active-high logic level
- SYNC_o  out  1  high for the whole X3 subcycle
- CM_o  out  1  memory control, high for the whole A3 subcycle of an active cycle
- D_o  out  4  data bus drive value
- D_oe_o  out  1  data bus output enable
- D_i  in  4  data bus sampled value

## Operation
- Phase counter runs continuously after reset: A1, A2, A3, M1, M2, X1, X2, X3, then back to A1.
- Each phase lasts ticks 0..3. PHI1_o is high in tick 0. PHI2_o is high in tick 2. PHI1_o and PHI2_o are never high together.
- req_ready_o is high only in X3 tick 3. A handshake in that clock marks the next instruction cycle active and latches req_addr_i. Otherwise the next cycle is idle.
- Active cycle bus behaviour:
  - A1: D_oe_o=1, D_o=addr[3:0]
  - A2: D_oe_o=1, D_o=addr[7:4]
  - A3: D_oe_o=1, D_o=addr[11:8], CM_o=1
- Active cycle capture:
  - M1: D_i is captured into OPR at the clock ending tick 2.
  - M2: D_i is captured into OPA at the clock ending tick 2.
  - rsp_valid_o=1 in M2 tick 3, with rsp_data_o={OPR,OPA}.
- M1 through X3: D_oe_o=0.
- Idle cycle: D_oe_o=0 and CM_o=0 throughout, no captures, no rsp_valid_o. PHI1_o, PHI2_o and SYNC_o keep running.
- rsp_data_o holds its last value between pulses.
- Whenever D_oe_o=0, D_o=0.
- Outputs are decoded from registered phase, tick, active and addr state only; there is no combinational path from req_* or D_i to any output.

## Timing
- Instruction cycle = 32 clk.
- If the handshake occurs in cycle c:
  - A1 tick 0 = c+1, A3 = c+9..c+12.
  - OPR captured at the end of c+15, OPA captured at the end of c+19.
  - rsp_valid_o in c+20.
- Maximum throughput: one fetch per 32 clk, back to back, with no bubble cycle.
- Request arrives mid-cycle: it waits for the next X3 tick 3. req_valid_i may drop before acceptance with no effect. req_addr_i is sampled only at the handshake.
- Reset:
  - While RESET_i=1, all outputs are 0 and rsp_data_o=0.
  - On release: phase=X3, tick=0, active=0. SYNC_o rises the next clk, and the first accept opportunity is 4 clk after release.
- Reset mid-operation: the in-flight fetch is dropped, no rsp_valid_o is produced, and the bus tristates immediately (asynchronously).
- Address wrap: the address is taken verbatim and the block does no increment; 12'hFFF is legal.

## Structure
- Package mcs4_pkg holds:
  - typedef enum phase_t {A1,A2,A3,M1,M2,X1,X2,X3}
  - TICKS_PER_PHASE=4, PHI1_TICK=0, PHI2_TICK=2, SAMPLE_TICK=2
  - the same definitions are shared later by i4002/i4004 models
- Sub-module mcs4_phase_gen: tick and phase counters plus the PHI1_o/PHI2_o/SYNC_o decode. It exports phase, tick, and a last_tick strobe.
- Top-level mcs4_rom_fetch holds the active flag, address latch, OPR/OPA registers and the D/CM decode.

## Test plan
- Reset release, no request: SYNC_o first high in clks 1..4 after release. Thereafter the period is 32 clk, PHI1_o and PHI2_o are each high 8 clk per cycle and never overlap, and D_oe_o=0 and CM_o=0 throughout.
- Single fetch of 12'h3A5 with the ROM model returning OPR=4'hD, OPA=4'h2:
  - D_o is 5, A, 3 during A1, A2, A3; CM_o is high only in A3.
  - rsp_valid_o goes high exactly 20 clk after the handshake with rsp_data_o=8'hD2.
- Back-to-back fetches of 12'h000 and 12'hFFF with req_valid_i held high: two handshakes 32 clk apart, two responses 32 clk apart, correct nibbles including F,F,F.
- req_valid_i pulsed for 3 clk in mid-X1 then dropped: no handshake, idle cycle follows, no rsp_valid_o.
- D_i glitches to 4'hF in every tick except tick 2 of M1/M2, where it is 4'h6 / 4'h9: rsp_data_o=8'h69.
- RESET_i asserted in M1 of an active fetch: outputs go to 0 asynchronously, no rsp_valid_o. After release, a new fetch of 12'h123 completes normally.
